// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-enabled data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;  // 2'd3 is reserved and behaves as a word

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    // Byte lanes touched by an access of the given size at the given lane offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane extraction: shifts the selected byte/half down to bit 0 and extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    // Pick the lane(s), then zero- or sign-extend; word loads pass through.
    always_comb begin
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: data = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable MEM-stage data memory with lane-masked stores, registered
// loads and a post-reset sequential clear. Optional misalignment checking is
// enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_memory_be
    import dmem_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  misaligned,
    output logic                  init_done
);

    localparam int AW = $clog2(DEPTH);

    state_e        state, state_nxt;
    logic [AW-1:0] cnt;
    logic [31:0]   mem [DEPTH];

    logic          accept, store_en, load_en, mis;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    wmask;
    logic [31:0]   wdata_rep, ld_data;

    // Upper address bits only alias the array, so they are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:AW+2];

    assign req_ready = (state == ST_RUN);
    assign init_done = (state == ST_RUN);
    assign accept    = req_valid & req_ready;
    assign idx       = req_addr[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
    // Keep the raw lane offset and flag accesses that straddle their natural alignment.
    always_comb begin
        lane = req_addr[1:0];
        case (req_size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            default: mis = (lane != 2'b00);
        endcase
    end
`else
    // Force the low address bits to the access's natural alignment.
    always_comb begin
        lane = req_addr[1:0];
        case (req_size)
            SZ_BYTE: lane = req_addr[1:0];
            SZ_HALF: lane = {req_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
        mis = 1'b0;
    end
`endif

    // Replicate store data across lanes so the mask alone selects what lands.
    always_comb begin
        wmask = lane_mask(req_size, lane);
        case (req_size)
            SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
            SZ_HALF: wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    assign store_en = accept & req_write & ~mis;
    assign load_en  = accept & ~req_write;

    dmem_load_align u_align (
        .word        (mem[idx]),
        .size        (req_size),
        .lane        (lane),
        .is_unsigned (req_unsigned),
        .data        (ld_data)
    );

    // State register and clear counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) cnt <= cnt + AW'(1);
        end
    end

    // Leave INIT after the last word is cleared, or at once when clearing is skipped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (INIT_CLEAR == 0 || cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Array writes: one zeroed word per cycle during INIT, lane-masked stores in RUN.
    always_ff @(posedge clk) begin
        if (INIT_CLEAR != 0 && state == ST_INIT) begin
            mem[cnt] <= '0;
        end else if (store_en) begin
            for (int l = 0; l < 4; l++)
                if (wmask[l]) mem[idx][8*l +: 8] <= wdata_rep[8*l +: 8];
        end
    end

    // Registered load response; data holds between loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            misaligned <= 1'b0;
        end else begin
            rsp_valid  <= load_en;
            misaligned <= accept & mis;
            if (load_en) rsp_rdata <= mis ? 32'd0 : ld_data;
        end
    end

endmodule
